// File: rtl/lift_ctrl_scan.sv
// lift_ctrl_scan: N-floor SCAN lift controller (requests in, pass events in -> floor/door/motion/occupancy outputs), async active-low rst
module lift_ctrl_scan #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLR_W       = 3,
  parameter int PASS_W      = 3,
  parameter int OCC_W       = 5,
  parameter int CAPACITY    = 12,
  parameter int MOVE_CYCLES = 3,
  parameter int DOOR_CYCLES = 4,
  parameter int FAN_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLR_W-1:0]      req_flr,
  input  logic                  pass_valid,
  input  logic [PASS_W-1:0]     pin,
  input  logic [PASS_W-1:0]     pout,
  output logic [FLR_W-1:0]      oflr,
  output logic                  door,
  output logic                  ol,
  output logic                  fan,
  output logic                  moving,
  output logic                  dir_up,
  output logic [OCC_W-1:0]      occ,
  output logic [NUM_FLOORS-1:0] pending
);
  localparam logic [1:0] IDLE = 2'd0, MOVE = 2'd1, DOOR_OPEN = 2'd2;
  localparam logic [15:0] MC = 16'(MOVE_CYCLES), DC = 16'(DOOR_CYCLES);
  logic [1:0] state;
  logic [15:0] mtmr, dtmr;
  logic arrive, decide, here, above, below, go_same, go_other, req_ok, door_hit;
  logic [FLR_W-1:0] nflr, dflr;
  logic [NUM_FLOORS-1:0] dmask, rmask, pend_nxt;
  logic [OCC_W:0] left, sum;
  logic [OCC_W-1:0] occ_n;
  // dflr is the floor the scheduling decision is made at: the arrival floor on a move-expiry edge
  always_comb begin
    arrive = state == MOVE && mtmr == MC - 16'd1;
    nflr = dir_up ? oflr + FLR_W'(1) : oflr - FLR_W'(1);
    dflr = arrive ? nflr : oflr;
    decide = state == IDLE || arrive;
    dmask = NUM_FLOORS'(1) << dflr;
    here = |(pending & dmask);
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above = above | (pending[i] && i > int'(dflr));
      below = below | (pending[i] && i < int'(dflr));
    end
    go_same = dir_up ? above : below;
    go_other = dir_up ? below : above;
    req_ok = req_valid && {1'b0, req_flr} < (FLR_W+1)'(NUM_FLOORS);
    door_hit = req_valid && state == DOOR_OPEN && req_flr == oflr;
    rmask = (req_ok && !door_hit) ? NUM_FLOORS'(1) << req_flr : '0;
    pend_nxt = (pending | rmask) & ~((decide && here) ? dmask : '0);
    left = ({1'b0, occ} >= (OCC_W+1)'(pout)) ? {1'b0, occ} - (OCC_W+1)'(pout) : '0;
    sum = left + (OCC_W+1)'(pin);
    occ_n = sum[OCC_W] ? '1 : sum[OCC_W-1:0];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      oflr <= '0;
      door <= 1'b0;
      ol <= 1'b0;
      fan <= 1'b0;
      moving <= 1'b0;
      dir_up <= 1'b1;
      occ <= '0;
      pending <= '0;
      mtmr <= '0;
      dtmr <= '0;
    end else begin
      pending <= pend_nxt;
      if (decide) begin
        oflr <= dflr;
        state <= here ? DOOR_OPEN : (go_same || go_other) ? MOVE : IDLE;
        door <= here;
        moving <= !here && (go_same || go_other);
        dir_up <= (!here && !go_same && go_other) ? !dir_up : dir_up;
        mtmr <= '0;
        dtmr <= here ? DC : '0;
      end else if (state == MOVE) mtmr <= mtmr + 16'd1;
      else if (state == DOOR_OPEN) begin
        if (pass_valid) begin
          occ <= occ_n;
          ol <= {1'b0, occ_n} > (OCC_W+1)'(CAPACITY);
          fan <= occ_n >= OCC_W'(FAN_THRESH);
          dtmr <= DC;
        end else if (door_hit) dtmr <= DC;
        else if (dtmr > 16'd1) dtmr <= dtmr - 16'd1;
        else if (!ol) begin
          door <= 1'b0;
          state <= IDLE;
          dtmr <= '0;
        end else dtmr <= '0;
      end else state <= IDLE;
    end
endmodule
